// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: serial-subtractor FSM states and counter sizing.
package arith_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sub_state_t;

    // Bits needed to count 0..w inclusive.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/full_sub.sv
// One-bit full subtractor built from two half-subtractor stages and an OR.
module full_sub (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    logic d1;
    logic b1;
    logic b2;

    // First half-subtractor: a - b
    assign d1   = a ^ b;
    assign b1   = ~a & b;

    // Second half-subtractor: (a - b) - bin
    assign diff = d1 ^ bin;
    assign b2   = ~d1 & bin;

    assign bout = b1 | b2;

endmodule

// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor: one full-subtractor cell, LSB first, WIDTH cycles per operation.
module serial_sub
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int unsigned CW = cnt_width(WIDTH);

    sub_state_t       state;
    sub_state_t       state_d;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] d_sr;
    logic             br;
    logic [CW-1:0]    cnt;

    logic             cell_d;
    logic             cell_b;
    logic [WIDTH-1:0] d_next_c;
    logic             load_c;
    logic             step_c;
    logic             last_c;

    // The single arithmetic cell, fed from the operand LSBs and the borrow flop
    full_sub u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (br),
        .diff (cell_d),
        .bout (cell_b)
    );

    // Result shift register with the new bit inserted at the MSB (works for WIDTH=1 too)
    assign d_next_c = (d_sr >> 1) | (WIDTH'(cell_d) << (WIDTH - 1));

    // Next-state and datapath control decode
    always_comb begin
        state_d = state;
        load_c  = 1'b0;
        step_c  = 1'b0;
        last_c  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load_c  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                step_c = 1'b1;
                if (cnt == CW'(WIDTH - 1)) begin
                    last_c  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Operand/result shift registers, borrow flop, bit counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr <= '0;
            b_sr <= '0;
            d_sr <= '0;
            br   <= 1'b0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            diff <= '0;
            bout <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load_c) begin
                a_sr <= a;
                b_sr <= b;
                br   <= bin;
                cnt  <= '0;
                busy <= 1'b1;
            end else if (step_c) begin
                a_sr <= a_sr >> 1;
                b_sr <= b_sr >> 1;
                d_sr <= d_next_c;
                br   <= cell_b;
                cnt  <= cnt + CW'(1);
                if (last_c) begin
                    diff <= d_next_c;
                    bout <= cell_b;
                    done <= 1'b1;
                    busy <= 1'b0;
                end
            end
        end
    end

endmodule
